spi_cmd_seq: RTL and testbench
==============================

SPI_CMD_SEQ -- requirements
Module: spi_cmd_seq

Interface
REQ-001 Parameter BITS, default 16, SPI word width; SHALL equal the downstream SPI master's word width.
REQ-002 Parameter DEPTH, default 8, entries per FIFO; power of two, at least 2.
REQ-003 Parameter GAP, default 2, idle clk cycles between the end of one transfer and the next launch; 0 allowed.
REQ-004 Parameter TMO, default 16, cycles to wait for spi_working to rise after launch.
REQ-005 clk  in  1  clock; reset rst, synchronous, active-high; clock clk.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 tx_data  in  BITS  word to transmit.
REQ-008 tx_valid  in  1  tx_data present.
REQ-009 tx_ready  out  1  TX FIFO not full.
REQ-010 rx_data  out  BITS  head of RX FIFO (show-ahead).
REQ-011 rx_valid  out  1  RX FIFO not empty.
REQ-012 rx_ready  in  1  consumer accepts rx_data.
REQ-013 spi_start  out  1  one-cycle launch pulse to the master.
REQ-014 spi_dout  out  BITS  word for the master; registered.
REQ-015 spi_din  in  BITS  master's received word.
REQ-016 spi_working  in  1  master transaction-active flag.
REQ-017 busy  out  1  high when the state is not IDLE.
REQ-018 tmo_err  out  1  sticky launch-timeout flag.

Function
REQ-019 TX push SHALL occur on tx_valid&tx_ready; a push while full SHALL be ignored, even if a pop happens in the same cycle.
REQ-020 RX pop SHALL occur on rx_valid&rx_ready; a pop while empty SHALL be ignored.
REQ-021 Simultaneous push and pop on a FIFO that is neither full nor empty SHALL leave its level unchanged.
REQ-022 Pointers SHALL wrap modulo DEPTH; the level counter SHALL be $clog2(DEPTH+1) bits wide.
REQ-023 The FSM SHALL have states IDLE, LAUNCH, WAIT_HI, WAIT_LO and GAPW.
REQ-024 IDLE->LAUNCH SHALL occur when TX is not empty, RX is not full, and spi_working=0; in the same cycle, TX SHALL pop and its head SHALL be registered into spi_dout.
REQ-025 In LAUNCH, spi_start=1 for exactly one cycle; the next state is WAIT_HI.
REQ-026 WAIT_HI SHALL go to WAIT_LO when spi_working=1.
REQ-027 If spi_working stays low for TMO cycles in WAIT_HI, the FSM SHALL set tmo_err and return to IDLE; no RX push occurs and the word is dropped.
REQ-028 In WAIT_LO, spi_working=0 SHALL push spi_din into RX in that cycle; the next state SHALL be GAPW if GAP>0, otherwise IDLE.
REQ-029 GAPW SHALL count GAP cycles and then go to IDLE.
REQ-030 RX SHALL never overflow, because launches are gated on RX not full and only one transfer is in flight.
REQ-031 spi_dout SHALL hold its value from LAUNCH until the next launch.
REQ-032 Minimum launch-to-launch time SHALL be the transfer length + GAP + 2 cycles.
REQ-033 tmo_err SHALL be cleared only by rst.

Reset
REQ-034 On rst: FSM=IDLE; both FIFOs empty; spi_start=0; spi_dout=0; busy=0; tmo_err=0; gap and timeout counters=0.
REQ-035 rst mid-transfer SHALL abort without an RX push; the master is reset by the same rst.

Structure
REQ-036 FSM state encoding and the constants BITS_DEF=16 and DEPTH_DEF=8 SHALL live in the shared package spi_pkg.
REQ-037 One sub-module, sync_fifo (params W, DEPTH), SHALL be instantiated twice, as the TX and RX FIFOs.

Verification
REQ-038 Push 0xA5C3 into an idle block with the master modelled in loopback -> spi_start pulses once; spi_dout=0xA5C3; rx_data=0xA5C3 with rx_valid after spi_working falls.
REQ-039 Push 8 words with rx_ready=0 and DEPTH=8 -> 8 transfers; rx_valid=1; no 9th launch after a 9th push until one RX pop.
REQ-040 Push 9 words back-to-back while idle -> tx_ready=0 at level 8 and the 9th word is ignored until a pop.
REQ-041 Never raise spi_working after launch, TMO=16 -> tmo_err=1 after 16 cycles in WAIT_HI, FSM in IDLE, RX empty.
REQ-042 GAP=2, two queued words -> exactly 2 idle cycles plus FSM overhead between spi_working falling and the second spi_start.
REQ-043 Assert rst in WAIT_LO -> all outputs return to their reset values next cycle and RX is empty.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI command sequencer.
// State encoding and default geometry.
package spi_pkg;

    localparam int BITS_DEF  = 16;
    localparam int DEPTH_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT_HI = 3'd2,
        ST_WAIT_LO = 3'd3,
        ST_GAPW    = 3'd4
    } seq_state_t;

    // Bits needed to count 0..n-1, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
// Push while full and pop while empty are dropped.
module sync_fifo
    import spi_pkg::*;
#(
    parameter int W     = BITS_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since level gates reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; level tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spi_cmd_seq.sv
// Queues words for an SPI master, launches one transfer at a time
// and collects the received words into an RX FIFO.
module spi_cmd_seq
    import spi_pkg::*;
#(
    parameter int BITS  = BITS_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int GAP   = 2,
    parameter int TMO   = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS-1:0] tx_data,
    input  logic            tx_valid,
    output logic            tx_ready,
    output logic [BITS-1:0] rx_data,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            spi_start,
    output logic [BITS-1:0] spi_dout,
    input  logic [BITS-1:0] spi_din,
    input  logic            spi_working,
    output logic            busy,
    output logic            tmo_err
);

    localparam int GW = cnt_width(GAP);
    localparam int TW = cnt_width(TMO);

    seq_state_t      state;
    logic [GW-1:0]   gap_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic [BITS-1:0] tx_head;
    logic            tx_full;
    logic            tx_empty;
    logic            rx_full;
    logic            rx_empty;
    logic            launch_ok;
    logic            rx_push;

    assign tx_ready  = !tx_full;
    assign rx_valid  = !rx_empty;

    // Only launch when the result has somewhere to go and the
    // master has finished whatever it was doing.
    assign launch_ok = (state == ST_IDLE) && !tx_empty
                       && !rx_full && !spi_working;
    assign rx_push   = (state == ST_WAIT_LO) && !spi_working;

    sync_fifo #(
        .W     (BITS),
        .DEPTH (DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_valid),
        .din   (tx_data),
        .pop   (launch_ok),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_fifo #(
        .W     (BITS),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (spi_din),
        .pop   (rx_ready),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // Transfer sequencer with registered start, word, busy and error.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            spi_start <= 1'b0;
            spi_dout  <= '0;
            busy      <= 1'b0;
            tmo_err   <= 1'b0;
            gap_cnt   <= '0;
            tmo_cnt   <= '0;
        end else begin
            spi_start <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (launch_ok) begin
                        spi_dout  <= tx_head;
                        spi_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    tmo_cnt <= '0;
                    state   <= ST_WAIT_HI;
                end
                ST_WAIT_HI: begin
                    if (spi_working) begin
                        state <= ST_WAIT_LO;
                    end else if (tmo_cnt == TW'(TMO - 1)) begin
                        tmo_err <= 1'b1;
                        busy    <= 1'b0;
                        state   <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ST_WAIT_LO: begin
                    if (!spi_working) begin
                        if (GAP > 0) begin
                            gap_cnt <= '0;
                            state   <= ST_GAPW;
                        end else begin
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_GAPW: begin
                    if (gap_cnt == GW'(GAP - 1)) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_seq.sv
// Directed bench for spi_cmd_seq with a loopback SPI master model.
// Launch words and received words are checked against queues.
module tb_spi_cmd_seq;

    localparam int XFER = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [15:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        spi_start;
    logic [15:0] spi_dout;
    logic [15:0] spi_din;
    logic        spi_working;
    logic        busy;
    logic        tmo_err;

    logic        master_en;
    logic        hold_work;
    logic        m_work;
    logic [15:0] m_word;
    int          m_cnt;

    int          vectors = 0;
    int          miscompares = 0;
    int          starts = 0;
    logic [31:0] exp_launch [$];
    logic [31:0] exp_rx [$];

    always #5 clk = ~clk;

    assign spi_working = m_work | hold_work;

    spi_cmd_seq #(
        .BITS  (16),
        .DEPTH (8),
        .GAP   (2),
        .TMO   (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .spi_start   (spi_start),
        .spi_dout    (spi_dout),
        .spi_din     (spi_din),
        .spi_working (spi_working),
        .busy        (busy),
        .tmo_err     (tmo_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Loopback master: busy for XFER cycles after a start, then
    // returns the word it was given.
    always @(posedge clk) begin
        if (rst) begin
            m_cnt   <= 0;
            m_work  <= 1'b0;
            m_word  <= '0;
            spi_din <= '0;
        end else if (spi_start && master_en) begin
            m_cnt  <= XFER;
            m_work <= 1'b1;
            m_word <= spi_dout;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_work  <= 1'b0;
                spi_din <= m_word;
            end
        end
    end

    // Every launch must carry the next accepted TX word.
    always @(negedge clk) begin : launch_mon
        logic [31:0] w;
        if (!rst && spi_start) begin
            starts++;
            if (exp_launch.size() != 0) w = exp_launch.pop_front();
            else w = 'x;
            chk("launch_dout", {16'h0, spi_dout}, w);
        end
    end

    task automatic push(input logic [15:0] w, input logic rdy,
                        input logic to_rx);
        @(negedge clk);
        chk("tx_ready", {31'h0, tx_ready}, {31'h0, rdy});
        tx_data  = w;
        tx_valid = 1'b1;
        if (rdy) begin
            exp_launch.push_back({16'h0, w});
            if (to_rx) exp_rx.push_back({16'h0, w});
        end
    endtask

    task automatic tx_end();
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_rx.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
            if (rx_valid) begin
                chk("rx_data", {16'h0, rx_data}, exp_rx.pop_front());
                rx_ready = 1'b1;
            end else begin
                rx_ready = 1'b0;
            end
        end
        @(negedge clk);
        rx_ready = 1'b0;
        chk("drain_left", exp_rx.size(), 0);
    endtask

    initial begin
        int n;
        int s0;
        rst       = 1'b1;
        tx_data   = '0;
        tx_valid  = 1'b0;
        rx_ready  = 1'b0;
        master_en = 1'b1;
        hold_work = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_tx_ready", {31'h0, tx_ready}, 1);
        chk("rst_rx_valid", {31'h0, rx_valid}, 0);
        chk("rst_start", {31'h0, spi_start}, 0);
        chk("rst_dout", {16'h0, spi_dout}, 0);
        chk("rst_busy", {31'h0, busy}, 0);
        chk("rst_tmo", {31'h0, tmo_err}, 0);
        rst = 1'b0;

        // Single loopback transfer.
        s0 = starts;
        push(16'hA5C3, 1'b1, 1'b1);
        tx_end();
        n = 0;
        while (!rx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t1_rx_valid", {31'h0, rx_valid}, 1);
        chk("t1_starts", starts - s0, 1);
        chk("t1_dout_hold", {16'h0, spi_dout}, 32'hA5C3);
        drain(20);

        // Fill RX with 8 results; the 9th must wait for a pop.
        s0 = starts;
        for (int i = 0; i < 8; i++) push(16'h1000 + 16'(i), 1'b1, 1'b1);
        tx_end();
        n = 0;
        while (!(starts == s0 + 8 && !busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t2_eight", starts - s0, 8);
        chk("t2_rx_valid", {31'h0, rx_valid}, 1);
        push(16'h1008, 1'b1, 1'b1);
        tx_end();
        repeat (30) @(negedge clk);
        chk("t2_no_ninth", starts - s0, 8);
        chk("t2_idle", {31'h0, busy}, 0);
        drain(400);
        chk("t2_ninth", starts - s0, 9);

        // TX fills to 8 while the master reports busy.
        hold_work = 1'b1;
        for (int i = 0; i < 8; i++) push(16'h2000 + 16'(i), 1'b1, 1'b1);
        push(16'h2008, 1'b0, 1'b1);
        tx_end();
        chk("t3_full", {31'h0, tx_ready}, 0);
        chk("t3_no_start", {31'h0, busy}, 0);
        hold_work = 1'b0;
        n = 0;
        while (!tx_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        push(16'h2008, 1'b1, 1'b1);
        tx_end();
        drain(600);

        // Master never answers: timeout after TMO cycles in WAIT_HI.
        master_en = 1'b0;
        push(16'h3333, 1'b1, 1'b0);
        tx_end();
        n = 0;
        while (!spi_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4_start", {31'h0, spi_start}, 1);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if (k == 16) begin
                chk("t4_tmo_early", {31'h0, tmo_err}, 0);
                chk("t4_busy_wait", {31'h0, busy}, 1);
            end
            if (k == 17) begin
                chk("t4_tmo_set", {31'h0, tmo_err}, 1);
                chk("t4_idle", {31'h0, busy}, 0);
                chk("t4_rx_empty", {31'h0, rx_valid}, 0);
            end
        end

        // Two queued words: GAP idle cycles plus overhead between them.
        master_en = 1'b1;
        push(16'h4001, 1'b1, 1'b1);
        push(16'h4002, 1'b1, 1'b1);
        tx_end();
        n = 0;
        while (!spi_working && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (spi_working && n < 20) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (!spi_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t5_gap", n, 4);
        drain(60);
        chk("t5_tmo_sticky", {31'h0, tmo_err}, 1);

        // Reset in WAIT_LO aborts without an RX push.
        push(16'h5555, 1'b1, 1'b0);
        tx_end();
        n = 0;
        while (!spi_working && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("t6_in_xfer", {31'h0, busy}, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_start", {31'h0, spi_start}, 0);
        chk("t6_dout", {16'h0, spi_dout}, 0);
        chk("t6_busy", {31'h0, busy}, 0);
        chk("t6_tmo", {31'h0, tmo_err}, 0);
        chk("t6_rx_empty", {31'h0, rx_valid}, 0);
        chk("t6_tx_ready", {31'h0, tx_ready}, 1);
        rst = 1'b0;
        push(16'h6789, 1'b1, 1'b1);
        tx_end();
        drain(60);
        chk("launch_left", exp_launch.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
